// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite read master: turns one core read request into an AR/R exchange and a one-cycle
// response strobe. Define AXI4_READ_TIMEOUT_EN to add a watchdog on the ADDR/DATA phases.
module axi4_lite_read_master #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     axi_clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_error,
    output logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic                     read_addr_valid,
    input  logic                     read_addr_ready,
    input  logic [31:0]              read_data,
    input  logic                     read_data_valid,
    input  logic [1:0]               read_resp,
    output logic                     read_data_ready,
    output logic                     busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic                     err_q, err_d;
    logic                     timeout;

    // Only the SLVERR/DECERR bit matters; OKAY and EXOKAY are both success.
    logic unused_resp_lsb;
    assign unused_resp_lsb = read_resp[0];

`ifdef AXI4_READ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Held at zero in IDLE so it starts from zero on every entry to ADDR.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StAddr || state_q == StData) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StAddr || state_q == StData) &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (read_addr_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                // A handshake on the final watchdog cycle still wins.
                if (read_data_valid) begin
                    data_d  = read_data;
                    err_d   = read_resp[1];
                    state_d = StResp;
                end else if (timeout) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready       = resetn && (state_q == StIdle);
    assign busy            = resetn && (state_q != StIdle);
    assign read_addr_valid = (state_q == StAddr);
    assign read_data_ready = (state_q == StData);
    assign rsp_valid       = (state_q == StResp);
    assign read_addr       = addr_q;
    assign rsp_data        = data_q;
    assign rsp_error       = err_q;

endmodule
